// File: rtl/state_dump_unit_pkg.sv
// state_dump_unit_pkg: shared FSM encoding, header magic and default geometry for the state dump unit.
package state_dump_unit_pkg;

    typedef enum logic [2:0] {IDLE, HDR, REG, MEM, CSUM, FIN} state_t;

    localparam logic [15:0] HDR_MAGIC        = 16'hD05E;
    localparam int          DEF_NUM_REGS     = 32;
    localparam int          DEF_DM_BASE_WORD = 20;
    localparam int          DEF_DM_WORDS     = 2;
    localparam int          DEF_DM_AW        = 10;

    function automatic logic [31:0] hdr_word(input int num_regs, input int dm_words);
        return {HDR_MAGIC, 8'(num_regs), 8'(dm_words)};
    endfunction

endpackage

// File: rtl/state_dump_unit_if.sv
// state_dump_unit_if: valid/ready word stream carrying the dump.
//   valid : data/last hold a word
//   ready : consumer takes the word this cycle
//   data  : stream word
//   last  : marks the checksum word closing a dump
interface state_dump_unit_if;
    logic        valid;
    logic        ready;
    logic [31:0] data;
    logic        last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/state_dump_unit_dump_out_reg.sv
// dump_out_reg: one-word output slot with valid/ready hold plus running XOR checksum.
//   clk, rst        : clock, async active-low reset
//   clr             : clear the checksum for a new dump
//   load            : write load_data/load_last into the slot (only issued when free)
//   free            : slot empty or being handed off this cycle
//   csum            : XOR of every non-last word loaded since clr
//   out             : stream master side
module dump_out_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        free,
    output logic [31:0] csum,
    state_dump_unit_if.master out
);

    assign free = !out.valid || out.ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out.valid <= 1'b0;
            out.data  <= '0;
            out.last  <= 1'b0;
            csum      <= '0;
        end else begin
            if (load) begin
                out.valid <= 1'b1;
                out.data  <= load_data;
                out.last  <= load_last;
            end else if (out.ready) begin
                out.valid <= 1'b0;
                out.last  <= 1'b0;
            end
            // the checksum word itself is never folded into the sum
            if (clr)
                csum <= '0;
            else if (load && !load_last)
                csum <= csum ^ load_data;
        end
    end

endmodule

// File: rtl/state_dump_unit.sv
// state_dump_unit: walks RF and a DM window on start and streams header, words and XOR checksum.
//   clk, rst          : clock, async active-low reset
//   start             : request a dump (ignored unless idle)
//   busy, done        : dump in progress / one-cycle completion pulse
//   rf_addr, rf_data  : spare RF read port (async read)
//   dm_addr, dm_data  : spare DM read port (async read)
//   out               : valid/ready word stream
module state_dump_unit
    import state_dump_unit_pkg::*;
#(
    parameter int NUM_REGS     = DEF_NUM_REGS,
    parameter int DM_BASE_WORD = DEF_DM_BASE_WORD,
    parameter int DM_WORDS     = DEF_DM_WORDS,
    parameter int DM_AW        = DEF_DM_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [4:0]       rf_addr,
    input  logic [31:0]      rf_data,
    output logic [DM_AW-1:0] dm_addr,
    input  logic [31:0]      dm_data,
    state_dump_unit_if.master out
);

    localparam logic [31:0] HDR_WORD = hdr_word(NUM_REGS, DM_WORDS);
    localparam logic [15:0] LAST_REG = 16'(NUM_REGS - 1);
    localparam logic [15:0] LAST_MEM = 16'(DM_WORDS - 1);

    state_t      state;
    logic [15:0] idx;
    logic        free, load, load_last;
    logic [31:0] load_data, csum;

    always_comb begin
        load      = free && (state == HDR || state == REG || state == MEM || state == CSUM);
        load_last = state == CSUM;
        load_data = state == HDR ? HDR_WORD :
                    state == REG ? (idx == '0 ? '0 : rf_data) :
                    state == MEM ? dm_data : csum;
    end

    // addresses are registered one step ahead so the async read data is ready when the slot frees
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rf_addr <= '0;
            dm_addr <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= HDR;
                    busy  <= 1'b1;
                end
                HDR: if (free) begin
                    idx     <= '0;
                    rf_addr <= '0;
                    state   <= REG;
                end
                REG: if (free) begin
                    if (idx == LAST_REG) begin
                        idx   <= '0;
                        state <= (DM_WORDS == 0) ? CSUM : MEM;
                        if (DM_WORDS != 0) dm_addr <= DM_AW'(DM_BASE_WORD);
                    end else begin
                        idx     <= idx + 16'd1;
                        rf_addr <= 5'(idx + 16'd1);
                    end
                end
                MEM: if (free) begin
                    if (idx == LAST_MEM) begin
                        state <= CSUM;
                    end else begin
                        idx     <= idx + 16'd1;
                        dm_addr <= DM_AW'(DM_BASE_WORD + 32'(idx) + 1);
                    end
                end
                CSUM: if (free) state <= FIN;
                FIN: if (out.ready) begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    dump_out_reg u_out (
        .clk       (clk),
        .rst       (rst),
        .clr       (state == IDLE && start),
        .load      (load),
        .load_data (load_data),
        .load_last (load_last),
        .free      (free),
        .csum      (csum),
        .out       (out)
    );

endmodule

// File: tb/tb_state_dump_unit.sv
// tb_state_dump_unit: scenario-table driven bench for state_dump_unit over three parameterisations.
module tb_state_dump_unit;
    import state_dump_unit_pkg::*;

    typedef struct {
        int          inst;
        int          period;
        bit          frc;
        bit          restart;
        int          nwords;
        logic [31:0] hdr;
    } scen_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  start_v = '0;
    logic        ready = 1'b0;
    logic        force_ff = 1'b0;
    logic [2:0]  busy_v, done_v;
    logic [4:0]  rf_addr0, rf_addr1, rf_addr2;
    logic [9:0]  dm_addr0, dm_addr1, dm_addr2;
    logic [31:0] rf_data0, rf_data1, rf_data2, dm_data0, dm_data1, dm_data2;
    logic [31:0] rf [32];
    logic [31:0] dmem [1024];
    int          checks = 0;
    int          errors = 0;
    int          sel = 0;
    logic        o_valid, o_last, o_busy, o_done;
    logic [31:0] o_data;
    logic [31:0] exp_q [$];
    scen_t       tbl [7];

    always #5 clk = ~clk;

    state_dump_unit_if s0 ();
    state_dump_unit_if s1 ();
    state_dump_unit_if s2 ();
    assign s0.ready = ready;
    assign s1.ready = ready;
    assign s2.ready = ready;

    assign rf_data0 = force_ff ? 32'hFFFF_FFFF : rf[rf_addr0];
    assign rf_data1 = force_ff ? 32'hFFFF_FFFF : rf[rf_addr1];
    assign rf_data2 = force_ff ? 32'hFFFF_FFFF : rf[rf_addr2];
    assign dm_data0 = dmem[dm_addr0];
    assign dm_data1 = dmem[dm_addr1];
    assign dm_data2 = dmem[dm_addr2];

    state_dump_unit #(.DM_BASE_WORD(DEF_DM_BASE_WORD), .DM_WORDS(DEF_DM_WORDS)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .rf_addr(rf_addr0), .rf_data(rf_data0), .dm_addr(dm_addr0), .dm_data(dm_data0), .out(s0));
    state_dump_unit #(.DM_BASE_WORD(1023), .DM_WORDS(0)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .rf_addr(rf_addr1), .rf_data(rf_data1), .dm_addr(dm_addr1), .dm_data(dm_data1), .out(s1));
    state_dump_unit #(.DM_BASE_WORD(1023), .DM_WORDS(2)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .rf_addr(rf_addr2), .rf_data(rf_data2), .dm_addr(dm_addr2), .dm_data(dm_data2), .out(s2));

    always_comb begin
        o_valid = sel == 0 ? s0.valid : sel == 1 ? s1.valid : s2.valid;
        o_data  = sel == 0 ? s0.data  : sel == 1 ? s1.data  : s2.data;
        o_last  = sel == 0 ? s0.last  : sel == 1 ? s1.last  : s2.last;
        o_busy  = busy_v[sel];
        o_done  = done_v[sel];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic build_exp(input scen_t sc);
        int base, dw;
        logic [31:0] x;
        base = sc.inst == 0 ? 20 : 1023;
        dw   = sc.inst == 1 ? 0 : 2;
        exp_q = {};
        exp_q.push_back(sc.hdr);
        exp_q.push_back(32'h0);
        for (int i = 1; i < 32; i++) exp_q.push_back(sc.frc ? 32'hFFFF_FFFF : rf[i]);
        for (int j = 0; j < dw; j++) exp_q.push_back(dmem[(base + j) % 1024]);
        x = '0;
        foreach (exp_q[i]) x ^= exp_q[i];
        exp_q.push_back(x);
    endtask

    task automatic run_dump(input scen_t sc);
        int k = 0, ndone = 0, first_v = -1, done_c = -1;
        bit stalled = 0, p5 = 0, p20 = 0;
        logic [31:0] held = '0;
        logic held_last = 1'b0;
        sel = sc.inst;
        force_ff = sc.frc;
        build_exp(sc);
        ready = 1'b0;
        @(negedge clk);
        start_v[sel] = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            start_v[sel] = 1'b0;
            if (sc.restart && k == 5 && !p5) begin start_v[sel] = 1'b1; p5 = 1; end
            if (sc.restart && k == 20 && !p20) begin start_v[sel] = 1'b1; p20 = 1; end
            if (c == 0) chk("busy_after_start", 32'(o_busy), 32'd1);
            if (stalled) begin
                chk("stall_valid", 32'(o_valid), 32'd1);
                chk("stall_data", o_data, held);
                chk("stall_last", 32'(o_last), 32'(held_last));
            end
            if (o_valid && first_v < 0) first_v = c;
            if (o_done) begin
                ndone++;
                if (done_c < 0) done_c = c;
            end
            if (done_c >= 0 && c >= done_c + 3) break;
            ready = (c % sc.period) == 0;
            if (o_valid && ready) begin
                chk($sformatf("word%0d", k), o_data, k < exp_q.size() ? exp_q[k] : 32'hDEAD_BEEF);
                chk($sformatf("last%0d", k), 32'(o_last), 32'(k == exp_q.size() - 1));
                k++;
                stalled = 0;
            end else begin
                stalled   = o_valid;
                held      = o_data;
                held_last = o_last;
            end
        end
        ready = 1'b0;
        force_ff = 1'b0;
        chk("word_count", 32'(k), 32'(sc.nwords));
        chk("done_pulses", 32'(ndone), 32'd1);
        chk("busy_end", 32'(o_busy), 32'd0);
        chk("valid_end", 32'(o_valid), 32'd0);
        if (sc.period == 1 && !sc.restart) begin
            chk("hdr_cycle", 32'(first_v), 32'd1);
            chk("done_cycle", 32'(done_c), 32'(sc.nwords + 1));
        end
        if (sc.inst == 0) chk("rf_addr_hold", 32'(rf_addr0), 32'd31);
        if (sc.inst == 1) chk("dm_addr_untouched", 32'(dm_addr1), 32'd0);
        if (sc.inst == 2) chk("dm_addr_wrap", 32'(dm_addr2), 32'd0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h1111_1111;
        for (int i = 0; i < 1024; i++) dmem[i] = 32'h0;
        dmem[20]   = 32'd55;
        dmem[21]   = 32'd10;
        dmem[1023] = 32'hCAFE_0001;
        dmem[0]    = 32'hBEEF_0002;
        tbl[0] = '{0, 1, 1'b0, 1'b0, 36, 32'hD05E_2002};
        tbl[1] = '{0, 3, 1'b0, 1'b0, 36, 32'hD05E_2002};
        tbl[2] = '{0, 1, 1'b1, 1'b0, 36, 32'hD05E_2002};
        tbl[3] = '{0, 1, 1'b0, 1'b1, 36, 32'hD05E_2002};
        tbl[4] = '{1, 1, 1'b0, 1'b0, 34, 32'hD05E_2000};
        tbl[5] = '{2, 1, 1'b0, 1'b0, 36, 32'hD05E_2002};
        tbl[6] = '{2, 2, 1'b0, 1'b0, 36, 32'hD05E_2002};

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy_v[0]), 32'd0);
        chk("rst_done", 32'(done_v[0]), 32'd0);
        chk("rst_valid", 32'(s0.valid), 32'd0);
        chk("rst_last", 32'(s0.last), 32'd0);
        chk("rst_data", s0.data, 32'd0);
        chk("rst_rf_addr", 32'(rf_addr0), 32'd0);
        chk("rst_dm_addr", 32'(dm_addr0), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int s = 0; s < 7; s++) run_dump(tbl[s]);

        // reset in the middle of a dump
        sel = 0;
        ready = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b1;
        n = 0;
        for (int c = 0; c < 50 && n < 10; c++) begin
            @(negedge clk);
            start_v[0] = 1'b0;
            if (s0.valid) n++;
        end
        chk("mid_words_seen", 32'(n), 32'd10);
        #2 rst = 1'b0;
        #1;
        chk("async_busy", 32'(busy_v[0]), 32'd0);
        chk("async_valid", 32'(s0.valid), 32'd0);
        chk("async_data", s0.data, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_rst_done", 32'(done_v[0]), 32'd0);
            chk("post_rst_busy", 32'(busy_v[0]), 32'd0);
            chk("post_rst_valid", 32'(s0.valid), 32'd0);
        end
        ready = 1'b0;
        run_dump(tbl[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
